window_3x3_gen: RTL

- Upstream neighbour of the per-pixel colour filter stages: converts a raster stream of 12-bit RGB444 pixels into 3x3 neighbourhood windows packed as the 108-bit color_data bus those stages consume.
- Holds two line buffers plus a 3x3 register window.
- Zero-pads all image borders (black).
- Emits exactly one window per image pixel, in raster order, then returns to idle for the next frame.

---
 rtl/window_3x3_gen.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: turns a raster stream of RGB444 pixels into zero-padded
// 3x3 neighbourhood windows. It uses two line buffers plus a 3x3 register
// window. A virtual pad column and a virtual pad row flush the borders, so
// exactly one window comes out per image pixel.
module window_3x3_gen #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120,
    parameter int COL_W      = 8,
    parameter int ROW_W      = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [11:0]  pixel_in,
    input  logic         in_valid,
    input  logic         in_sof,
    output logic         in_ready,
    output logic [107:0] color_data,
    output logic         data_valid,
    output logic         out_eof
);
    localparam int DATA_W = 12;
    localparam logic [COL_W-1:0] LAST_COL    = COL_W'(IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] PAD_COL_IDX = COL_W'(IMG_WIDTH);
    localparam logic [ROW_W-1:0] PAD_ROW_IDX = ROW_W'(IMG_HEIGHT);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_PAD_COL, S_PAD_ROW} state_t;

    state_t             state, state_d;
    logic [ROW_W-1:0]   row, row_d;
    logic [COL_W-1:0]   col, col_d;
    logic               accept;

    logic               step_p0;
    logic [COL_W-1:0]   addr_p0;
    logic [ROW_W-1:0]   srow_p0;
    logic [DATA_W-1:0]  pix_p0;
    logic               emit_p0, eof_p0;
    logic               m_top_p0, m_left_p0, m_right_p0, m_bot_p0;

    logic [DATA_W-1:0]  lb0 [0:IMG_WIDTH];
    logic [DATA_W-1:0]  lb1 [0:IMG_WIDTH];
    logic [DATA_W-1:0]  lb0_rd, lb1_rd;

    // Window columns: index 0 = left, 1 = centre, 2 = right.
    logic [2:0][DATA_W-1:0] w_top, w_mid, w_bot;
    logic [2:0][DATA_W-1:0] n_top, n_mid, n_bot;

    // Packs the window into the output bus; masked rows/columns are forced to black.
    function automatic logic [107:0] pack_window(
        input logic [2:0][DATA_W-1:0] top, mid, bot,
        input logic m_top, m_left, m_right, m_bot
    );
        logic [2:0][DATA_W-1:0] t, m, b;
        t = m_top ? '0 : top;
        m = mid;
        b = m_bot ? '0 : bot;
        if (m_left) begin
            t[0] = '0; m[0] = '0; b[0] = '0;
        end
        if (m_right) begin
            t[2] = '0; m[2] = '0; b[2] = '0;
        end
        return {m[1], m[0], m[2], t[1], b[1], t[0], t[2], b[0], b[2]};
    endfunction

    assign in_ready = !reset && (state == S_IDLE || state == S_ACTIVE);
    assign accept   = in_valid && in_ready;

    // ---- stage p0: step decode, line-buffer read, window shift ----

    // Next-state, counter advance and step position for this cycle.
    always_comb begin
        state_d = state;
        row_d   = row;
        col_d   = col;
        step_p0 = 1'b0;
        addr_p0 = col;
        srow_p0 = row;
        pix_p0  = '0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    step_p0 = 1'b1;
                    addr_p0 = '0;
                    srow_p0 = '0;
                    pix_p0  = pixel_in;
                    row_d   = '0;
                    col_d   = COL_W'(1);
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    step_p0 = 1'b1;
                    pix_p0  = pixel_in;
                    if (in_sof && (row != '0 || col != '0)) begin
                        // Resync: this pixel restarts the frame as step (0,0).
                        addr_p0 = '0;
                        srow_p0 = '0;
                        row_d   = '0;
                        col_d   = COL_W'(1);
                    end else if (col == LAST_COL) begin
                        col_d   = PAD_COL_IDX;
                        state_d = S_PAD_COL;
                    end else begin
                        col_d   = col + COL_W'(1);
                    end
                end
            end
            S_PAD_COL: begin
                step_p0 = 1'b1;
                col_d   = '0;
                row_d   = row + ROW_W'(1);
                state_d = (row + ROW_W'(1) == PAD_ROW_IDX) ? S_PAD_ROW : S_ACTIVE;
            end
            S_PAD_ROW: begin
                step_p0 = 1'b1;
                if (col == PAD_COL_IDX) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    col_d   = col + COL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line-buffer read, shifted window and border masks for the current step.
    always_comb begin
        lb0_rd     = lb0[addr_p0];
        lb1_rd     = lb1[addr_p0];
        n_top      = {lb1_rd, w_top[2], w_top[1]};
        n_mid      = {lb0_rd, w_mid[2], w_mid[1]};
        n_bot      = {pix_p0, w_bot[2], w_bot[1]};
        emit_p0    = step_p0 && (srow_p0 != '0) && (addr_p0 != '0);
        m_top_p0   = (srow_p0 == ROW_W'(1));
        m_left_p0  = (addr_p0 == COL_W'(1));
        m_right_p0 = (addr_p0 == PAD_COL_IDX);
        m_bot_p0   = (srow_p0 == PAD_ROW_IDX);
        eof_p0     = m_bot_p0 && m_right_p0;
    end

    // Control registers: FSM state and step counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            row   <= '0;
            col   <= '0;
        end else begin
            state <= state_d;
            row   <= row_d;
            col   <= col_d;
        end
    end

    // Line buffers: age row r-1 into the r-2 buffer and store the new pixel.
    always_ff @(posedge clk) begin
        if (step_p0) begin
            lb1[addr_p0] <= lb0_rd;
            lb0[addr_p0] <= pix_p0;
        end
    end

    // Window shift register; stale contents are hidden by the border masks.
    always_ff @(posedge clk) begin
        if (step_p0) begin
            w_top <= n_top;
            w_mid <= n_mid;
            w_bot <= n_bot;
        end
    end

    // ---- stage p1: registered, masked window output ----

    // Output register: one-cycle valid pulse with the masked, packed window.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_valid <= 1'b0;
            out_eof    <= 1'b0;
            color_data <= '0;
        end else begin
            data_valid <= emit_p0;
            out_eof    <= emit_p0 && eof_p0;
            if (emit_p0) begin
                color_data <= pack_window(n_top, n_mid, n_bot,
                                          m_top_p0, m_left_p0, m_right_p0, m_bot_p0);
            end
        end
    end
endmodule
